// File: rtl/int_controller.sv
// External interrupt controller: synchronises and edge-captures request lines,
// arbitrates fixed priority, and drives the intr/inta handshake until Eoi.
module int_controller #(
    parameter int NIRQ = 8
) (
    input  logic            Clk,
    input  logic            Clrn,
    input  logic [NIRQ-1:0] Irq,
    output logic            intr,
    input  logic            inta,
    input  logic            WeMask,
    input  logic [NIRQ-1:0] MaskIn,
    input  logic            Eoi,
    output logic [2:0]      IrqId,
    output logic            InService,
    output logic [NIRQ-1:0] Pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] SERV = 2'd2;

    logic [NIRQ-1:0] s1_q, s2_q, s3_q;
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] mask_q;
    logic [1:0]      state_q, state_d;
    logic            intr_q;
    logic [2:0]      id_q, id_d;

    logic [NIRQ-1:0] edge_w;
    logic [NIRQ-1:0] cand;
    logic [NIRQ-1:0] win_oh;
    logic [2:0]      win_id;
    logic            ack;
    logic [NIRQ-1:0] clr;

    assign edge_w = s2_q & ~s3_q;
    assign cand   = pend_q & ~mask_q;
    assign ack    = (state_q == REQ) && inta;
    assign clr    = ack ? win_oh : '0;

    // Lowest-numbered candidate wins; scan downward so the last hit is lowest.
    always_comb begin
        win_oh = '0;
        win_id = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = 3'(i);
            end
        end
    end

    // A new edge on the bit being acknowledged is a second event, so set wins.
    always_comb begin
        pend_d = (pend_q & ~clr) | edge_w;
    end

    // Request/acknowledge/service sequencing; no nesting while in service.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (cand != '0) state_d = REQ;
            end
            REQ: begin
                if (inta) begin
                    state_d = SERV;
                    id_d    = win_id;
                end else if (cand == '0) begin
                    state_d = IDLE;
                end
            end
            SERV: begin
                if (Eoi) begin
                    state_d = IDLE;
                    id_d    = 3'd0;
                end
            end
            default: begin
                state_d = IDLE;
                id_d    = 3'd0;
            end
        endcase
    end

    // Synchroniser, edge history, pending and mask registers.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            pend_q <= '0;
            mask_q <= '1;
        end else begin
            s1_q   <= Irq;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            pend_q <= pend_d;
            if (WeMask) mask_q <= MaskIn;
        end
    end

    // State, registered intr and in-service id.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
            id_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            intr_q  <= (state_d == REQ);
            id_q    <= id_d;
        end
    end

    assign intr      = intr_q;
    assign IrqId     = id_q;
    assign InService = (state_q == SERV);
    assign Pending   = pend_q;

endmodule

// File: tb/tb_int_controller.sv
// Directed testbench for int_controller: capture, priority, masking,
// re-trigger during service, protocol abuse and asynchronous reset.
module tb_int_controller;

    logic       Clk = 1'b0;
    logic       Clrn = 1'b0;
    logic [7:0] Irq = '0;
    logic       intr;
    logic       inta = 1'b0;
    logic       WeMask = 1'b0;
    logic [7:0] MaskIn = '0;
    logic       Eoi = 1'b0;
    logic [2:0] IrqId;
    logic       InService;
    logic [7:0] Pending;

    int checks = 0;
    int errors = 0;

    int_controller #(.NIRQ(8)) dut (
        .Clk(Clk), .Clrn(Clrn), .Irq(Irq), .intr(intr), .inta(inta),
        .WeMask(WeMask), .MaskIn(MaskIn), .Eoi(Eoi), .IrqId(IrqId),
        .InService(InService), .Pending(Pending)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Irq = '0; inta = 0; WeMask = 0; Eoi = 0; MaskIn = '0;
        Clrn = 0;
        tick(2);
        Clrn = 1;
        tick(1);
    endtask

    task automatic unmask_all();
        WeMask = 1; MaskIn = 8'h00;
        tick(1);
        WeMask = 0;
    endtask

    task automatic ack();
        inta = 1;
        tick(1);
        inta = 0;
    endtask

    task automatic eoi();
        Eoi = 1;
        tick(1);
        Eoi = 0;
    endtask

    task automatic test_reset();
        Clrn = 0;
        tick(2);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL rst_intr got %b exp 0", intr); end
        checks++; if (InService !== 1'b0) begin errors++; $display("FAIL rst_insvc got %b exp 0", InService); end
        checks++; if (IrqId !== 3'd0) begin errors++; $display("FAIL rst_id got %0d exp 0", IrqId); end
        checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL rst_pend got %h exp 00", Pending); end
        Clrn = 1;
        tick(1);
    endtask

    task automatic test_single();
        unmask_all();
        Irq[5] = 1;
        tick(3);
        Irq[5] = 0;
        checks++; if (Pending !== 8'h20) begin errors++; $display("FAIL single_pend got %h exp 20", Pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_intr_e2 got %b exp 0", intr); end
        tick(1);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL single_intr_e3 got %b exp 1", intr); end
        ack();
        checks++; if (IrqId !== 3'd5) begin errors++; $display("FAIL single_id got %0d exp 5", IrqId); end
        checks++; if (InService !== 1'b1) begin errors++; $display("FAIL single_insvc got %b exp 1", InService); end
        checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL single_pend_clr got %h exp 00", Pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_intr_ack got %b exp 0", intr); end
        eoi();
        checks++; if (IrqId !== 3'd0) begin errors++; $display("FAIL single_id_eoi got %0d exp 0", IrqId); end
        tick(1);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL single_intr_eoi got %b exp 0", intr); end
    endtask

    task automatic test_priority();
        Irq = 8'h44;
        tick(3);
        Irq = '0;
        checks++; if (Pending !== 8'h44) begin errors++; $display("FAIL prio_pend got %h exp 44", Pending); end
        tick(1);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL prio_intr got %b exp 1", intr); end
        ack();
        checks++; if (IrqId !== 3'd2) begin errors++; $display("FAIL prio_id1 got %0d exp 2", IrqId); end
        checks++; if (Pending !== 8'h40) begin errors++; $display("FAIL prio_pend1 got %h exp 40", Pending); end
        eoi();
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL prio_gap got %b exp 0", intr); end
        tick(1);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL prio_intr2 got %b exp 1", intr); end
        ack();
        checks++; if (IrqId !== 3'd6) begin errors++; $display("FAIL prio_id2 got %0d exp 6", IrqId); end
        eoi();
    endtask

    task automatic test_masking();
        do_reset();
        Irq[0] = 1;
        tick(3);
        Irq[0] = 0;
        tick(3);
        checks++; if (Pending !== 8'h01) begin errors++; $display("FAIL mask_pend got %h exp 01", Pending); end
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask_blocked got %b exp 0", intr); end
        unmask_all();
        tick(1);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL mask_open got %b exp 1", intr); end
        WeMask = 1; MaskIn = 8'h01;
        tick(1);
        WeMask = 0;
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL mask_lag got %b exp 1", intr); end
        tick(1);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL mask_drop got %b exp 0", intr); end
        checks++; if (Pending !== 8'h01) begin errors++; $display("FAIL mask_keep got %h exp 01", Pending); end
        unmask_all();
        tick(1);
        ack();
        checks++; if (IrqId !== 3'd0 || InService !== 1'b1) begin errors++; $display("FAIL mask_ack got id %0d svc %b exp 0 1", IrqId, InService); end
        eoi();
    endtask

    task automatic test_nesting();
        Irq[3] = 1;
        tick(3);
        Irq[3] = 0;
        tick(3);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL nest_req got %b exp 1", intr); end
        Irq = 8'h0A;
        tick(2);
        ack();
        checks++; if (IrqId !== 3'd3) begin errors++; $display("FAIL nest_id3 got %0d exp 3", IrqId); end
        checks++; if (Pending !== 8'h0A) begin errors++; $display("FAIL nest_pend got %h exp 0a", Pending); end
        Irq = '0;
        tick(3);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL nest_block got %b exp 0", intr); end
        checks++; if (IrqId !== 3'd3) begin errors++; $display("FAIL nest_hold got %0d exp 3", IrqId); end
        eoi();
        tick(1);
        ack();
        checks++; if (IrqId !== 3'd1) begin errors++; $display("FAIL nest_id1 got %0d exp 1", IrqId); end
        checks++; if (Pending !== 8'h08) begin errors++; $display("FAIL nest_pend2 got %h exp 08", Pending); end
        eoi();
        tick(1);
        ack();
        checks++; if (IrqId !== 3'd3) begin errors++; $display("FAIL nest_id3b got %0d exp 3", IrqId); end
        eoi();
    endtask

    task automatic test_abuse();
        Irq = 8'h06;
        tick(3);
        Irq = '0;
        tick(1);
        inta = 1;
        tick(5);
        inta = 0;
        checks++; if (IrqId !== 3'd1) begin errors++; $display("FAIL abuse_id got %0d exp 1", IrqId); end
        checks++; if (Pending !== 8'h04) begin errors++; $display("FAIL abuse_pend got %h exp 04", Pending); end
        eoi();
        tick(1);
        ack();
        eoi();
        tick(1);
        eoi();
        checks++; if (intr !== 1'b0 || InService !== 1'b0 || IrqId !== 3'd0) begin errors++; $display("FAIL abuse_eoi_idle got %b %b %0d exp 0 0 0", intr, InService, IrqId); end
        Irq[4] = 1;
        tick(4);
        checks++; if (intr !== 1'b1) begin errors++; $display("FAIL hold_req got %b exp 1", intr); end
        ack();
        eoi();
        tick(94);
        checks++; if (intr !== 1'b0) begin errors++; $display("FAIL hold_once got %b exp 0", intr); end
        checks++; if (Pending !== 8'h00) begin errors++; $display("FAIL hold_pend got %h exp 00", Pending); end
        Irq = '0;
        tick(3);
    endtask

    task automatic test_async_reset();
        Irq = 8'h18;
        tick(3);
        Irq = '0;
        tick(1);
        ack();
        checks++; if (IrqId !== 3'd3 || Pending !== 8'h10) begin errors++; $display("FAIL ares_pre got id %0d pend %h exp 3 10", IrqId, Pending); end
        #2;
        Clrn = 0;
        #1;
        checks++; if (intr !== 1'b0 || InService !== 1'b0) begin errors++; $display("FAIL ares_ctl got %b %b exp 0 0", intr, InService); end
        checks++; if (IrqId !== 3'd0 || Pending !== 8'h00) begin errors++; $display("FAIL ares_st got id %0d pend %h exp 0 00", IrqId, Pending); end
        tick(1);
        Clrn = 1;
        Irq[0] = 1;
        tick(3);
        Irq[0] = 0;
        tick(3);
        checks++; if (Pending !== 8'h01 || intr !== 1'b0) begin errors++; $display("FAIL ares_mask got pend %h intr %b exp 01 0", Pending, intr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_masking();
        test_nesting();
        test_abuse();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_controller.md
# int_controller

External interrupt controller for the single-cycle MIPS CPU with CP0 exception support. It synchronises up to eight asynchronous interrupt request lines and latches their rising edges as pending requests. It presents a single level `intr` to the control unit and accepts the control unit's `inta` acknowledge. On acknowledge it reports the serviced line's id until software signals end-of-interrupt (EOI).

## Interface

- `NIRQ`, default 8: number of request lines; legal range 1..8.
- `Clk`, input, 1 bit: system clock. All state updates on the rising edge.
- `Clrn`, input, 1 bit: asynchronous, active-low reset.
- `Irq`, input, `NIRQ` bits: asynchronous external requests; each line is rising-edge triggered.
- `intr`, output, 1 bit: interrupt request to the control unit. Registered.
- `inta`, input, 1 bit: acknowledge from the control unit. Sampled only in state REQ.
- `WeMask`, input, 1 bit: write strobe for the mask register.
- `MaskIn`, input, `NIRQ` bits: new mask value; bit = 1 masks the line.
- `Eoi`, input, 1 bit: end-of-interrupt strobe, from the ISR via an MMIO decode.
- `IrqId`, output, 3 bits: id of the line in service; 0 when not in service.
- `InService`, output, 1 bit: high while in state SERV.
- `Pending`, output, `NIRQ` bits: pending-request register, readable by software.

## Operation

Request capture, per line:
- 2-flop synchroniser (`s1`, `s2`) feeds a history flop `s3`.
- `edge = s2 & ~s3`.
- `edge` sets `Pending[i]` on the next clock.
- `Pending[i]` clears only when line i is acknowledged.
- If set and clear hit the same bit in the same cycle, set wins. The new edge is a second event and is kept.
- Masking never clears `Pending`; it only blocks arbitration.

Arbitration:
- `cand = Pending & ~Mask`.
- Winner = lowest-numbered set bit of `cand` (line 0 has highest priority).

State machine:
- IDLE: `intr` = 0. If `cand` ≠ 0, go to REQ.
- REQ: `intr` = 1.
  - If `inta` = 1: latch winner into `IrqId`, clear its pending bit, go to SERV.
  - Else if `cand` = 0 (masked by a mask write): go to IDLE.
  - Else stay in REQ.
  - The winner is evaluated at the acknowledge edge. A higher-priority request that arrived after entering REQ is the one serviced.
- SERV: `intr` = 0, `InService` = 1, `IrqId` held.
  - `inta` is ignored.
  - `Eoi` = 1 → go to IDLE and set `IrqId` to 0.
  - No nesting: new requests accumulate in `Pending`.

Other rules:
- `Eoi` outside SERV is ignored.
- `WeMask` loads `Mask` from `MaskIn` on the clock edge; the new mask affects arbitration from the next cycle.
- `inta` held high for several cycles causes exactly one acknowledge, because the state leaves REQ.
- Reset values, also applied immediately on a mid-operation `Clrn` assertion:
  - state IDLE, `intr` 0, `InService` 0, `IrqId` 0;
  - `Pending` all 0, `s1`/`s2`/`s3` all 0;
  - `Mask` all 1 (everything masked).
- A pulse on `Irq` must be high for at least 2 clocks to be guaranteed captured.
- `Irq` held high produces exactly one request. The line must return low and rise again to make a new one.

## Timing

- Let E0 be the clock edge that first samples `Irq[i]` high, with line i unmasked and the controller in IDLE.
  - E1: `s2` = 1, `edge` asserted.
  - E2: `Pending[i]` = 1.
  - E3: state REQ, `intr` = 1.
- `inta` high before edge Ek, with the controller in REQ:
  - after Ek: `intr` = 0, `InService` = 1, `IrqId` valid, `Pending[id]` = 0.
  - `intr` is therefore high for a minimum of 1 cycle.
- `Eoi` high before edge Em, in SERV:
  - after Em: IDLE, `IrqId` = 0.
  - If `cand` ≠ 0, REQ at Em+1 and `intr` = 1 after Em+1 (2-cycle gap minimum).
- A mask write that removes the only candidate while in REQ:
  - after the write edge, the mask updates;
  - one edge later, state IDLE and `intr` = 0.
  - If `inta` arrives on that following edge, it still acknowledges, because the state is still REQ.

## Test plan

- Reset then single request: `Clrn` low→high; `WeMask`=1 with `MaskIn`=8'h00; pulse `Irq[5]` for 3 clocks → `intr` rises 3 edges after sampling; `inta` pulse → `IrqId`=5, `InService`=1, `Pending`=0; `Eoi` → `IrqId`=0, `intr` stays 0.
- Priority: `Irq[6]` and `Irq[2]` rise in the same cycle → `Pending`=8'h44; first ack gives `IrqId`=2; after `Eoi`, `intr` returns 2 edges later; second ack gives `IrqId`=6.
- Masking: reset mask 8'hFF; pulse `Irq[0]` → `Pending`=8'h01, `intr` stays 0. Write mask 8'h00 → `intr`=1. While in REQ, write mask 8'h01 → `intr` drops, `Pending` still 8'h01.
- Nesting blocked and re-trigger: during SERV of line 3, `Irq[1]` rises, and `Irq[3]` rises again in the same cycle the line-3 ack clears its bit → `Pending`=8'h0A; `intr` stays 0 until `Eoi`; then ack gives `IrqId`=1.
- Protocol abuse: `inta` held high for 5 cycles → exactly one acknowledge; `Eoi` in IDLE → no change; `Irq[4]` held high for 100 cycles → one request only.
- Async reset mid-service: in SERV with `Pending`=8'h10, drive `Clrn`=0 between clock edges → `intr`, `InService`, `IrqId`, `Pending` go to 0 without waiting for a clock edge, and `Mask` reads 8'hFF afterward.
